// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types for the memory-unit arbiter
package mem_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_WAIT_VALID
    } arb_state_t;

    typedef enum logic {
        ARB_I,
        ARB_D
    } arb_owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - grant picker; MEM_ARB_ROUND_ROBIN_EN selects alternating grant on contention
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic       i_start,
    input  logic       d_start,
    input  arb_owner_t last_grant,
    output arb_owner_t grant
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_comb begin
        grant = ARB_I;
        if (i_start && d_start) begin
            grant = (last_grant == ARB_D) ? ARB_I : ARB_D;
        end else if (d_start) begin
            grant = ARB_D;
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    // the memory stage holds the older instruction, so it wins ties
    always_comb begin
        grant = d_start ? ARB_D : ARB_I;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares the memory unit between fetch and memory stage (MEM_ARB_ROUND_ROBIN_EN, PRINT_DEBUGINFO)
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_cmd_start,
    output logic                  i_cmd_ready,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_valid,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_cmd_start,
    input  logic                  d_cmd_write,
    output logic                  d_cmd_ready,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic [DATA_WIDTH-1:0] d_wmask,
    output logic                  d_valid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  memu_cmd_start,
    output logic                  memu_cmd_write,
    input  logic                  memu_cmd_ready,
    input  logic                  memu_valid,
    output logic [ADDR_WIDTH-1:0] memu_addr,
    output logic [DATA_WIDTH-1:0] memu_wdata,
    output logic [DATA_WIDTH-1:0] memu_wmask,
    input  logic [DATA_WIDTH-1:0] memu_rdata
);

    arb_state_t state, next_state;
    arb_owner_t owner, last_grant, grant;
    logic       accept;
    logic       grant_update;

    mem_arb_pick u_pick (
        .i_start    (i_cmd_start),
        .d_start    (d_cmd_start),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign accept = memu_cmd_start & memu_cmd_ready;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    assign grant_update = accept;
`else
    assign grant_update = accept & ~memu_cmd_write;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB_IDLE;
            owner      <= ARB_I;
            last_grant <= ARB_I;
        end else begin
            state <= next_state;
            if (accept && !memu_cmd_write) begin
                owner <= grant;
            end
            if (grant_update) begin
                last_grant <= grant;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ARB_IDLE:       if (accept && !memu_cmd_write) next_state = ARB_WAIT_VALID;
            ARB_WAIT_VALID: if (memu_valid) next_state = ARB_IDLE;
            default:        next_state = ARB_IDLE;
        endcase
    end

    // handshakes are gated by rst so they drop in the reset cycle itself
    always_comb begin
        memu_cmd_start = 1'b0;
        memu_cmd_write = 1'b0;
        memu_addr      = i_addr;
        memu_wdata     = '0;
        memu_wmask     = '0;
        i_cmd_ready    = 1'b0;
        d_cmd_ready    = 1'b0;
        i_valid        = 1'b0;
        d_valid        = 1'b0;
        if (grant == ARB_D) begin
            memu_cmd_write = d_cmd_write;
            memu_addr      = d_addr;
            memu_wdata     = d_wdata;
            memu_wmask     = d_wmask;
        end
        if (!rst && state == ARB_IDLE) begin
            memu_cmd_start = (grant == ARB_D) ? d_cmd_start : i_cmd_start;
            i_cmd_ready    = (grant == ARB_I) & memu_cmd_ready;
            d_cmd_ready    = (grant == ARB_D) & memu_cmd_ready;
        end
        if (!rst && state == ARB_WAIT_VALID) begin
            i_valid = memu_valid & (owner == ARB_I);
            d_valid = memu_valid & (owner == ARB_D);
        end
    end

    assign i_rdata = memu_rdata;
    assign d_rdata = memu_rdata;

`ifdef PRINT_DEBUGINFO
    always_ff @(posedge clk) begin
        $display("data,arb_state,%%d,%0d", state);
        $display("data,arb_owner,%%d,%0d", owner);
        $display("data,arb_grant,%%d,%0d", grant);
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter (honours MEM_ARB_ROUND_ROBIN_EN)
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_cmd_start, i_cmd_ready, i_valid;
    logic [31:0] i_addr, i_rdata;
    logic        d_cmd_start, d_cmd_write, d_cmd_ready, d_valid;
    logic [31:0] d_addr, d_wdata, d_wmask, d_rdata;
    logic        memu_cmd_start, memu_cmd_write, memu_cmd_ready, memu_valid;
    logic [31:0] memu_addr, memu_wdata, memu_wmask, memu_rdata;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_cmd_start    (i_cmd_start),
        .i_cmd_ready    (i_cmd_ready),
        .i_addr         (i_addr),
        .i_valid        (i_valid),
        .i_rdata        (i_rdata),
        .d_cmd_start    (d_cmd_start),
        .d_cmd_write    (d_cmd_write),
        .d_cmd_ready    (d_cmd_ready),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_wmask        (d_wmask),
        .d_valid        (d_valid),
        .d_rdata        (d_rdata),
        .memu_cmd_start (memu_cmd_start),
        .memu_cmd_write (memu_cmd_write),
        .memu_cmd_ready (memu_cmd_ready),
        .memu_valid     (memu_valid),
        .memu_addr      (memu_addr),
        .memu_wdata     (memu_wdata),
        .memu_wmask     (memu_wmask),
        .memu_rdata     (memu_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        i_cmd_start = 0; i_addr = 0;
        d_cmd_start = 0; d_cmd_write = 0; d_addr = 0; d_wdata = 0; d_wmask = 0;
        memu_cmd_ready = 0; memu_valid = 0; memu_rdata = 0;
    endtask

    task automatic d_store(input logic [31:0] addr, input logic [31:0] data);
        d_cmd_start = 1; d_cmd_write = 1; d_addr = addr; d_wdata = data; d_wmask = 32'hff;
    endtask

    task automatic d_load(input logic [31:0] addr);
        d_cmd_start = 1; d_cmd_write = 0; d_addr = addr; d_wdata = 0; d_wmask = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        rst = 1;
        // handshakes held low during reset even with requests and a stray response
        i_cmd_start = 1; i_addr = 32'h100; memu_cmd_ready = 1; memu_valid = 1;
        step(); step();
        check("rst_i_ready", i_cmd_ready, 0);
        check("rst_memu_start", memu_cmd_start, 0);
        check("rst_i_valid", i_valid, 0);
        check("rst_d_valid", d_valid, 0);
        clear_inputs();
        rst = 0;
        step();

        // 1: i-read, response three cycles later
        i_cmd_start = 1; i_addr = 32'h100; memu_cmd_ready = 1;
        settle();
        check("t1_i_ready", i_cmd_ready, 1);
        check("t1_memu_start", memu_cmd_start, 1);
        check("t1_memu_addr", memu_addr, 32'h100);
        check("t1_memu_write", memu_cmd_write, 0);
        check("t1_d_ready", d_cmd_ready, 0);
        step();
        i_cmd_start = 0;
        settle();
        check("t1_wait_start", memu_cmd_start, 0);
        check("t1_wait_i_valid", i_valid, 0);
        step();
        check("t1_wait2_i_valid", i_valid, 0);
        step();
        memu_valid = 1; memu_rdata = 32'hdeadbeef;
        settle();
        check("t1_i_valid", i_valid, 1);
        check("t1_i_rdata", i_rdata, 32'hdeadbeef);
        check("t1_d_valid", d_valid, 0);
        step();
        memu_valid = 0;

        // 2: d store stays IDLE, i-read granted the next cycle
        d_store(32'h2000, 32'h12345678);
        settle();
        check("t2_d_ready", d_cmd_ready, 1);
        check("t2_memu_write", memu_cmd_write, 1);
        check("t2_memu_wmask", memu_wmask, 32'hff);
        check("t2_memu_wdata", memu_wdata, 32'h12345678);
        check("t2_memu_addr", memu_addr, 32'h2000);
        step();
        d_cmd_start = 0; d_cmd_write = 0;
        i_cmd_start = 1; i_addr = 32'h104;
        settle();
        check("t2_i_ready", i_cmd_ready, 1);
        check("t2_i_wmask", memu_wmask, 0);
        check("t2_i_addr", memu_addr, 32'h104);
        step();
        i_cmd_start = 0; memu_valid = 1; memu_rdata = 32'h11;
        settle();
        check("t2_i_valid", i_valid, 1);
        step();
        memu_valid = 0;

        // dropped request: start without ready issues nothing and changes no state
        memu_cmd_ready = 0; i_cmd_start = 1; i_addr = 32'h108;
        settle();
        check("drop_i_ready", i_cmd_ready, 0);
        step();
        i_cmd_start = 0; memu_cmd_ready = 1;
        d_store(32'h2004, 32'h55);
        settle();
        check("drop_then_d_ready", d_cmd_ready, 1);
        step();
        clear_inputs();
        memu_cmd_ready = 1;

        // 3+4: contention after a d grant; the loser waits out the winner's read
        i_cmd_start = 1; i_addr = 32'h200;
        d_load(32'h40);
        settle();
`ifdef MEM_ARB_ROUND_ROBIN_EN
        check("t3_rr_i_ready", i_cmd_ready, 1);
        check("t3_rr_d_ready", d_cmd_ready, 0);
        check("t3_rr_addr", memu_addr, 32'h200);
        step();
        i_cmd_start = 0;
        settle();
        check("t4_d_ready_wait", d_cmd_ready, 0);
        check("t4_start_wait", memu_cmd_start, 0);
        step();
        memu_valid = 1; memu_rdata = 32'h77;
        settle();
        check("t4_i_valid", i_valid, 1);
        check("t4_d_valid", d_valid, 0);
        check("t4_d_ready_resp", d_cmd_ready, 0);
        step();
        memu_valid = 0;
        settle();
        check("t4_d_ready_after", d_cmd_ready, 1);
        check("t4_d_addr_after", memu_addr, 32'h40);
        step();
        d_cmd_start = 0;
        memu_valid = 1; memu_rdata = 32'h88;
        settle();
        check("t4_d_valid_after", d_valid, 1);
        check("t4_d_rdata_after", d_rdata, 32'h88);
`else
        check("t3_fp_d_ready", d_cmd_ready, 1);
        check("t3_fp_i_ready", i_cmd_ready, 0);
        check("t3_fp_addr", memu_addr, 32'h40);
        step();
        d_cmd_start = 0;
        settle();
        check("t4_i_ready_wait", i_cmd_ready, 0);
        check("t4_start_wait", memu_cmd_start, 0);
        step();
        memu_valid = 1; memu_rdata = 32'h77;
        settle();
        check("t4_d_valid", d_valid, 1);
        check("t4_d_rdata", d_rdata, 32'h77);
        check("t4_i_valid", i_valid, 0);
        check("t4_i_ready_resp", i_cmd_ready, 0);
        step();
        memu_valid = 0;
        settle();
        check("t4_i_ready_after", i_cmd_ready, 1);
        check("t4_i_addr_after", memu_addr, 32'h200);
        step();
        i_cmd_start = 0;
        memu_valid = 1; memu_rdata = 32'h88;
        settle();
        check("t4_i_valid_after", i_valid, 1);
        check("t4_i_rdata_after", i_rdata, 32'h88);
`endif
        step();
        clear_inputs();
        memu_cmd_ready = 1;

        // 5: reset during an outstanding read, late response dropped
        i_cmd_start = 1; i_addr = 32'h300;
        step();
        i_cmd_start = 0;
        rst = 1;
        step();
        rst = 0;
        step();
        memu_valid = 1; memu_rdata = 32'hbad;
        settle();
        check("t5_i_valid", i_valid, 0);
        check("t5_d_valid", d_valid, 0);
        i_cmd_start = 1; i_addr = 32'h304;
        settle();
        check("t5_idle_i_ready", i_cmd_ready, 1);
        step();
        i_cmd_start = 0; memu_valid = 1; memu_rdata = 32'h1234;
        settle();
        check("t5_i_valid_new", i_valid, 1);
        step();
        clear_inputs();
        memu_cmd_ready = 1;

        // 6: amoswap load+store while fetch requests continuously
        i_cmd_start = 1; i_addr = 32'h500;
        d_load(32'h3000);
        settle();
        check("t6_load_ready", d_cmd_ready, 1);
        check("t6_load_addr", memu_addr, 32'h3000);
        check("t6_load_write", memu_cmd_write, 0);
        step();
        d_cmd_start = 0;
        settle();
        check("t6_wait_i_ready", i_cmd_ready, 0);
        memu_valid = 1; memu_rdata = 32'h5;
        settle();
        check("t6_load_valid", d_valid, 1);
        check("t6_load_rdata", d_rdata, 32'h5);
        step();
        memu_valid = 0;
        d_store(32'h3000, 32'h9);
        settle();
`ifdef MEM_ARB_ROUND_ROBIN_EN
        check("t6_rr_i_between", i_cmd_ready, 1);
        check("t6_rr_d_held", d_cmd_ready, 0);
        step();
        memu_valid = 1; memu_rdata = 32'haa;
        settle();
        check("t6_rr_i_valid", i_valid, 1);
        step();
        memu_valid = 0;
        settle();
`endif
        check("t6_store_ready", d_cmd_ready, 1);
        check("t6_store_write", memu_cmd_write, 1);
        check("t6_store_wdata", memu_wdata, 32'h9);
        check("t6_store_i_ready", i_cmd_ready, 0);
        step();
        d_cmd_start = 0; d_cmd_write = 0;
        settle();
        check("t6_after_i_ready", i_cmd_ready, 1);
        check("t6_after_addr", memu_addr, 32'h500);
        step();
        clear_inputs();
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
